// File: rtl/dmem_responder.sv
// dmem_responder: target-side data memory for the MEM stage.
// One load/store at a time over req valid/ready. Byte-masked stores commit
// at accept, and the response returns after LATENCY cycles over rsp valid/ready.
// Optional feature macro: DMEM_RANGE_CHECK_EN. When defined, word indices
// >= DEPTH are flagged with rsp_err. Otherwise indices wrap modulo DEPTH.
module dmem_responder #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [7:0]        req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]   mem_idx;
    logic               in_range;
    logic               accept;
    logic               wr_en;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  wr_word;

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [ADDR_W-4:0] DEPTH_LIM = (ADDR_W-3)'(DEPTH);
    logic [ADDR_W-4:0] word_idx;
    logic              unused_addr_lsb;
    assign word_idx        = req_addr[ADDR_W-1:3];
    assign in_range        = (word_idx < DEPTH_LIM);
    assign mem_idx         = word_idx[IDX_W-1:0];
    assign unused_addr_lsb = ^req_addr[2:0];
`else
    // Out-of-range words alias onto the array through the low index bits.
    logic unused_addr_bits;
    assign in_range         = 1'b1;
    assign mem_idx          = req_addr[3 +: IDX_W];
    assign unused_addr_bits = ^{req_addr[2:0], req_addr[ADDR_W-1:3+IDX_W]};
`endif

    // Requests are only taken in IDLE and never while reset is held.
    assign req_ready = (state_q == ST_IDLE) && !sys_rst;
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_we && in_range;
    assign rd_word   = mem[mem_idx];

    // Merge enabled store lanes over the current word contents.
    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < 8; i++) begin
            if (req_wmask[i]) begin
                wr_word[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end
    end

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[mem_idx] <= wr_word;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Pre-write word is captured; for stores it is don't-care.
                    rsp_rdata_d = in_range ? rd_word : '0;
                    rsp_err_d   = !in_range;
                    cnt_d       = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Control and response registers; reset drops any pending response.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance for the main
// load/store/backpressure/reset cases and one LATENCY=1 instance for
// back-to-back minimum-latency traffic.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;

    logic        req_valid1, req_ready1, req_we1;
    logic [63:0] req_addr1, req_wdata1;
    logic [7:0]  req_wmask1;
    logic        rsp_valid1, rsp_ready1, rsp_err1;
    logic [63:0] rsp_rdata1;

    int n_vec = 0;
    int n_err = 0;

    dmem_responder #(.DATA_W(64), .ADDR_W(64), .DEPTH(1024), .LATENCY(2)) u_dut (
        .sys_clk(clk), .sys_rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DATA_W(64), .ADDR_W(64), .DEPTH(16), .LATENCY(1)) u_dut_lat1 (
        .sys_clk(clk), .sys_rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_wmask(req_wmask1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on the LATENCY=2 instance; holds rsp_ready low for 'hold'
    // cycles after rsp_valid appears, then releases it.
    task automatic xact(input string tag, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] mask, input int hold,
                        output logic [63:0] rdata, output logic err);
        int g;
        int lat;
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, rdata);
            chk({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_done_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_done_ready"}, 64'(req_ready), 64'd1);
    endtask

    logic [63:0] rd;
    logic        er;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        rsp_ready = 1'b0;
        req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_wmask1 = '0;
        rsp_ready1 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err",   64'(rsp_err), 64'd0);
        chk("rst_lat1_ready", 64'(req_ready1), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_req_ready", 64'(req_ready), 64'd1);
        chk("rel_lat1_ready", 64'(req_ready1), 64'd1);

        // Minimum latency: store then streaming loads, rsp_ready tied high
        req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 64'h8;
        req_wdata1 = 64'h5A5A_0F0F_1234_8765; req_wmask1 = 8'hFF; rsp_ready1 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("lat1_valid", 64'(rsp_valid1), 64'((i % 2) == 0));
            chk("lat1_ready", 64'(req_ready1), 64'((i % 2) == 1));
            if (i >= 2 && (i % 2) == 0) begin
                chk("lat1_rdata", rsp_rdata1, 64'h5A5A_0F0F_1234_8765);
            end
            req_we1 = 1'b0;
        end
        req_valid1 = 1'b0;

        // Full-word store then load
        xact("st_full", 1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 0, rd, er);
        chk("st_full_err", 64'(er), 64'd0);
        xact("ld_full", 1'b0, 64'h10, 64'h0, 8'h00, 0, rd, er);
        chk("ld_full_rdata", rd, 64'h1122334455667788);
        chk("ld_full_err", 64'(er), 64'd0);

        // Byte-masked store
        xact("st_mask", 1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, rd, er);
        xact("ld_mask", 1'b0, 64'h10, 64'h0, 8'h00, 0, rd, er);
        chk("ld_mask_rdata", rd, 64'h11223344AAAAAAAA);

        // Backpressure for 5 cycles
        xact("bp", 1'b0, 64'h10, 64'h0, 8'h00, 5, rd, er);
        chk("bp_rdata", rd, 64'h11223344AAAAAAAA);

        // Out of range: word index DEPTH = byte address 0x2000
        xact("st_w0", 1'b1, 64'h0, 64'h0123456789ABCDEF, 8'hFF, 0, rd, er);
        xact("st_oor", 1'b1, 64'h2000, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, rd, er);
`ifdef DMEM_RANGE_CHECK_EN
        chk("st_oor_err", 64'(er), 64'd1);
        chk("st_oor_rdata", rd, 64'd0);
        xact("ld_oor", 1'b0, 64'h2000, 64'h0, 8'h00, 0, rd, er);
        chk("ld_oor_err", 64'(er), 64'd1);
        chk("ld_oor_rdata", rd, 64'd0);
        xact("ld_w0", 1'b0, 64'h0, 64'h0, 8'h00, 0, rd, er);
        chk("ld_w0_rdata", rd, 64'h0123456789ABCDEF);
`else
        chk("st_oor_err", 64'(er), 64'd0);
        xact("ld_oor", 1'b0, 64'h2000, 64'h0, 8'h00, 0, rd, er);
        chk("ld_oor_err", 64'(er), 64'd0);
        chk("ld_oor_rdata", rd, 64'hDEADBEEFCAFEF00D);
        xact("ld_w0", 1'b0, 64'h0, 64'h0, 8'h00, 0, rd, er);
        chk("ld_w0_rdata", rd, 64'hDEADBEEFCAFEF00D);
`endif

        // Reset while in WAIT after a store to 0x20
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h20;
        req_wdata = 64'hFEDCBA9876543210; req_wmask = 8'hFF; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mid_wait_valid", 64'(rsp_valid), 64'd0);
        chk("mid_wait_ready", 64'(req_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_post_valid", 64'(rsp_valid), 64'd0);
            chk("mid_post_ready", 64'(req_ready), 64'd1);
        end
        xact("ld_after_rst", 1'b0, 64'h20, 64'h0, 8'h00, 0, rd, er);
        chk("ld_after_rst_rdata", rd, 64'hFEDCBA9876543210);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
